load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory port: turns CPU byte-addressed load/store requests into word
//  accesses on the single-port data memory (MemWrite=1 write, else synchronous read, 1-cycle RD).
//  Adds byte/halfword access (read-modify-write for sub-word stores), sign/zero extension,
//  alignment and range checking. Sits between the MIPS datapath and the data memory.
// PARAMETERS
//  MEM_WORDS  32  number of 32-bit words in the data memory; word index >= MEM_WORDS is an error
//  ADDR_W     32  width of CPU byte address and memory address ports
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  req_valid   in   1       CPU request present
//  req_ready   out  1       high only in IDLE; transfer on req_valid && req_ready
//  req_we      in   1       1 = store, 0 = load
//  req_size    in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_signed  in   1       loads: 1 sign-extend, 0 zero-extend; ignored for stores
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   32      store data, right-justified
//  resp_valid  out  1       one-cycle pulse completing each accepted request; no backpressure
//  resp_err    out  1       valid with resp_valid: misaligned, illegal size or out of range
//  resp_rdata  out  32      load result (0 for stores and errors)
//  mem_we      out  1       to memory MemWrite
//  mem_addr    out  ADDR_W  to memory ADDR, word index (req_addr >> 2)
//  mem_wd      out  32      to memory WD
//  mem_rd      in   32      from memory RD, valid the cycle after read address sampled
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1 (after reset release), resp_valid=0, resp_err=0,
//   resp_rdata=0, mem_we=0, mem_addr=0, mem_wd=0. All outputs registered.
//  Little-endian lanes: byte lane = addr[1:0], lane0 = bits[7:0]; half lane = addr[1].
//  Errors (checked at accept, memory untouched, mem_we stays 0): size 11; half with addr[0]=1;
//   word with addr[1:0]!=0; (addr>>2) >= MEM_WORDS. -> RESP next cycle, resp_err=1, rdata=0.
//  FSM: IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_CAP, RMW_WR, RESP.
//   IDLE: on accept latch addr/size/signed/wdata; -> RESP(err) | LD_RD | ST_WR (word) | RMW_RD.
//   LD_RD: mem_addr driven, mem_we=0; memory samples -> LD_CAP.
//   LD_CAP: extract lane from mem_rd, extend per req_signed into resp_rdata -> RESP.
//   ST_WR: mem_we=1, mem_wd=req_wdata for exactly one cycle -> RESP.
//   RMW_RD -> RMW_CAP: capture mem_rd, merge new byte/half into its lane (other lanes kept)
//   -> RMW_WR: mem_we=1 one cycle with merged word -> RESP.
//   RESP: resp_valid=1 one cycle -> IDLE (req_ready high again next cycle).
//  Latency accept-edge to resp_valid: load 3 cycles, word store 2, sub-word store 4, error 1.
//  mem_we is high only in ST_WR/RMW_WR, never two consecutive cycles; mem_addr stable through
//   each access. Back-to-back requests: one request in flight; next accepted the cycle after RESP.
//  req_* ignored when req_ready=0; request fields latched, CPU may change them after accept.
//  Reset mid-operation: immediate return to IDLE, mem_we forced 0 asynchronously; a pending
//   write (incl. RMW) is dropped, no resp_valid for the aborted request.
//  Memory-mapped I/O words (switch word, LED word) are treated as ordinary RAM words.
// STRUCTURE
//  Shared package mips_mem_pkg: size codes SZ_BYTE/SZ_HALF/SZ_WORD, FSM state encoding,
//   MEM_WORDS default; shared with the data memory and the CPU decoder.
//  Sub-module lsu_align (combinational): lane extract + sign/zero extend for loads, lane merge
//   for sub-word stores. FSM and registers stay in load_store_unit.
// TESTING
//  Bench memory model: 1-cycle registered read, write on MemWrite, MEM_WORDS=32.
//  1 Word store addr 0x10, data 0xDEADBEEF, then word load 0x10 -> mem word 4 = 0xDEADBEEF,
//    rdata 0xDEADBEEF, resp 2 and 3 cycles after accept, err=0.
//  2 Byte loads of word 0x80F17F01 at addr 0x0..0x3: signed -> 0x00000001, 0x0000007F,
//    0xFFFFFFF1, 0xFFFFFF80; unsigned lane3 -> 0x00000080.
//  3 Sub-word stores on 0x11223344: byte 0xAA at addr 0x2 -> 0x11AA3344; half 0xBEEF at 0x2
//    -> 0xBEEF3344; exactly one mem_we pulse each, resp 4 cycles after accept.
//  4 Errors: half at 0x1, word at 0x6, size 11, word at 0x80 -> resp_err=1 next cycle,
//    rdata 0, mem_we never asserted, memory unchanged.
//  5 Assert rst_n=0 during RMW_CAP of byte store -> mem_we 0, no write, no resp_valid,
//    req_ready=1 after release, target word unchanged.
//  6 Random back-to-back traffic vs reference model; check req_ready low while busy,
//    one resp per accept, mem_we never high two consecutive cycles.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Definitions shared by the load/store unit, the data memory and the CPU
// decoder: access size codes, the load/store FSM state encoding, the default
// data-memory depth and a helper that classifies malformed access shapes.
// -----------------------------------------------------------------------------
package mips_mem_pkg;

    localparam int MEM_WORDS_DEFAULT = 32;

    // Access size codes as carried on req_size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_RD   = 3'd1,
        S_LD_CAP  = 3'd2,
        S_ST_WR   = 3'd3,
        S_RMW_RD  = 3'd4,
        S_RMW_CAP = 3'd5,
        S_RMW_WR  = 3'd6,
        S_RESP    = 3'd7
    } lsu_state_t;

    // True for an illegal size or a size/low-address combination that is not
    // naturally aligned. Range checking depends on the memory depth and is
    // done by the caller.
    function automatic logic shape_error(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_ILL)
            || ((size == SZ_HALF) && lo[0])
            || ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// CPU-side request/response bundle of the load/store unit.
//   req_valid/req_ready  request handshake
//   req_we, req_size, req_signed, req_addr, req_wdata  request fields
//   resp_valid, resp_err, resp_rdata                   completion
// Modports: master = CPU datapath, slave = load_store_unit.
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both high; the request fields are only looked at on that edge
// and may change freely afterwards. req_ready is high only while the unit is
// idle. Each transferred request is completed by exactly one single-cycle
// resp_valid pulse; the response cannot be stalled by the CPU.
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational lane logic for the load/store unit (little-endian lanes).
//   size      access size code
//   lane      byte address bits [1:0]
//   sign_ext  1 = sign-extend sub-word loads, 0 = zero-extend
//   word      word read from memory
//   wdata     right-justified store data
//   load_val  extracted and extended load result
//   merged    word with the store data inserted into its lane
// -----------------------------------------------------------------------------
module lsu_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v   = word[{lane, 3'b000} +: 8];
        half_v   = lane[1] ? word[31:16] : word[15:0];
        load_val = word;
        merged   = word;
        case (size)
            SZ_BYTE: begin
                load_val = {{24{sign_ext & byte_v[7]}}, byte_v};
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_val = {{16{sign_ext & half_v[15]}}, half_v};
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Initiator side of the single-port data memory. Turns byte-addressed CPU
// loads/stores (byte, half, word) into word accesses; sub-word stores are done
// as read-modify-write. Misaligned, illegal-size and out-of-range requests are
// answered with resp_err without touching memory.
//   clk, rst_n  clock, asynchronous active-low reset
//   cpu         request/response bundle (slave side)
//   mem_we      memory write strobe
//   mem_addr    memory word index
//   mem_wd      memory write data
//   mem_rd      memory read data, valid the cycle after the address is sampled
//   dbg_state   current FSM state
// -----------------------------------------------------------------------------
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int ADDR_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   cpu,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [31:0]        mem_wd,
    input  logic [31:0]        mem_rd,
    output lsu_state_t         dbg_state
);
    localparam logic [ADDR_W-1:0] MEM_WORDS_A = ADDR_W'(MEM_WORDS);

    lsu_state_t  state, state_n;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        signed_q;
    logic [31:0] wdata_q;
    logic        accept;
    logic        req_err;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign accept  = cpu.req_valid && cpu.req_ready;
    assign req_err = shape_error(cpu.req_size, cpu.req_addr[1:0])
                  || ({2'b00, cpu.req_addr[ADDR_W-1:2]} >= MEM_WORDS_A);
    assign dbg_state = state;

    lsu_align u_align (
        .size     (size_q),
        .lane     (lane_q),
        .sign_ext (signed_q),
        .word     (mem_rd),
        .wdata    (wdata_q),
        .load_val (load_val),
        .merged   (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)                     state_n = S_RESP;
                    else if (!cpu.req_we)            state_n = S_LD_RD;
                    else if (cpu.req_size == SZ_WORD) state_n = S_ST_WR;
                    else                             state_n = S_RMW_RD;
                end
            end
            S_LD_RD:   state_n = S_LD_CAP;
            S_LD_CAP:  state_n = S_RESP;
            S_ST_WR:   state_n = S_RESP;
            S_RMW_RD:  state_n = S_RMW_CAP;
            S_RMW_CAP: state_n = S_RMW_WR;
            S_RMW_WR:  state_n = S_RESP;
            S_RESP:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Request fields are latched on accept; mem_addr then stays put for the
    // whole access, including both halves of a read-modify-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q   <= SZ_BYTE;
            lane_q   <= 2'b00;
            signed_q <= 1'b0;
            wdata_q  <= 32'd0;
            mem_addr <= '0;
        end else if (accept) begin
            size_q   <= cpu.req_size;
            lane_q   <= cpu.req_addr[1:0];
            signed_q <= cpu.req_signed;
            wdata_q  <= cpu.req_wdata;
            mem_addr <= {2'b00, cpu.req_addr[ADDR_W-1:2]};
        end
    end

    // Outputs are registered from the next state so each one lines up with
    // the state it belongs to. The only path into RESP straight from IDLE is
    // an error, which is what resp_err decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu.req_ready  <= 1'b1;
            cpu.resp_valid <= 1'b0;
            cpu.resp_err   <= 1'b0;
            cpu.resp_rdata <= 32'd0;
            mem_we         <= 1'b0;
            mem_wd         <= 32'd0;
        end else begin
            cpu.req_ready  <= (state_n == S_IDLE);
            cpu.resp_valid <= (state_n == S_RESP);
            cpu.resp_err   <= (state == S_IDLE) && (state_n == S_RESP);
            cpu.resp_rdata <= (state == S_LD_CAP) ? load_val : 32'd0;
            mem_we         <= (state_n == S_ST_WR) || (state_n == S_RMW_WR);
            if (state_n == S_ST_WR)       mem_wd <= cpu.req_wdata;
            else if (state_n == S_RMW_WR) mem_wd <= merged;
            else                          mem_wd <= 32'd0;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import mips_mem_pkg::*;

  localparam int MEM_WORDS = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) cpu_if ();
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  lsu_state_t  dbg_state;

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu       (cpu_if),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd),
    .dbg_state (dbg_state)
  );

  // ---------------- data memory model ----------------
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] init_val [MEM_WORDS];
  logic        init_req = 1'b1;

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_val[i];
    end else if (mem_we) begin
      mem[mem_addr[4:0]] <= mem_wd;
    end
    mem_rd <= mem[mem_addr[4:0]];
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] exp_q [$];
  logic        chk_en = 1'b0;
  logic        in_flight = 1'b0;
  int          age = 0;
  logic        cur_err;
  int          cur_lat;
  int          cur_writes;
  int          cur_widx;
  logic [31:0] cur_wval;
  int          writes_seen = 0;
  logic        prev_we = 1'b0;
  int          last_lat = 0;
  int          last_writes = 0;
  logic        last_err = 1'b0;
  logic [31:0] last_rdata = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what a request must do, from the access rules.
  task automatic model_accept(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w;
    logic [31:0] v;
    int sh;
    int idx;
    idx = int'(a >> 2);
    v = 32'd0;
    cur_writes = 0;
    cur_widx = 0;
    cur_wval = 32'd0;
    cur_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
              || ((a >> 2) >= MEM_WORDS);
    if (cur_err) begin
      cur_lat = 1;
    end else begin
      w = ref_mem[idx];
      sh = (sz == 2'b00) ? int'(a[1:0]) * 8 : int'(a[1]) * 16;
      if (!we) begin
        cur_lat = 3;
        if (sz == 2'b00) begin
          v = (w >> sh) & 32'hFF;
          if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
          v = (w >> sh) & 32'hFFFF;
          if (sg && v[15]) v = v | 32'hFFFF_0000;
        end else begin
          v = w;
        end
      end else begin
        cur_writes = 1;
        cur_widx = idx;
        if (sz == 2'b10) begin
          cur_lat = 2;
          cur_wval = wd;
        end else if (sz == 2'b00) begin
          cur_lat = 4;
          cur_wval = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        end else begin
          cur_lat = 4;
          cur_wval = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        end
      end
    end
    exp_q.push_back(v);
    writes_seen = 0;
    age = 0;
    last_lat = 0;
    in_flight = 1'b1;
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [31:0] rd_exp;
    logic        exp_valid;
    int          mism;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("we_consecutive", {31'd0, mem_we & prev_we}, 32'd0);
        prev_we = mem_we;
        if (in_flight) begin
          age++;
          if (mem_we) writes_seen++;
        end else begin
          chk("we_when_idle", {31'd0, mem_we}, 32'd0);
        end
        exp_valid = in_flight && (age == cur_lat);
        chk("req_ready", {31'd0, cpu_if.req_ready}, {31'd0, ~in_flight});
        chk("resp_valid", {31'd0, cpu_if.resp_valid}, {31'd0, exp_valid});
        if (cpu_if.resp_valid && in_flight) last_lat = age;
        if (exp_valid) begin
          rd_exp = exp_q.pop_front();
          chk("resp_err", {31'd0, cpu_if.resp_err}, {31'd0, cur_err});
          chk("resp_rdata", cpu_if.resp_rdata, rd_exp);
          chk("write_pulses", writes_seen, cur_writes);
          if (cur_writes != 0) ref_mem[cur_widx] = cur_wval;
          mism = 0;
          for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) mism++;
          chk("mem_contents", mism, 0);
          last_err = cpu_if.resp_err;
          last_rdata = cpu_if.resp_rdata;
          last_writes = writes_seen;
          in_flight = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_junk();
    cpu_if.req_valid  = 1'($urandom_range(0, 1));
    cpu_if.req_we     = 1'($urandom_range(0, 1));
    cpu_if.req_size   = 2'($urandom_range(0, 3));
    cpu_if.req_signed = 1'($urandom_range(0, 1));
    cpu_if.req_addr   = $urandom_range(0, 127);
    cpu_if.req_wdata  = $urandom;
  endtask

  task automatic send(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    while (cpu_if.req_ready !== 1'b1 && n < 16) begin
      @(negedge clk); #1;
      n++;
    end
    chk("ready_wait", {31'd0, cpu_if.req_ready}, 32'd1);
    cpu_if.req_valid  = 1'b1;
    cpu_if.req_we     = we;
    cpu_if.req_size   = sz;
    cpu_if.req_signed = sg;
    cpu_if.req_addr   = a;
    cpu_if.req_wdata  = wd;
    @(posedge clk);
    model_accept(we, sz, sg, a, wd);
    #1;
  endtask

  task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    int n;
    send(we, sz, sg, a, wd);
    n = 0;
    while (in_flight && n < 20) begin
      drive_junk();
      @(negedge clk); #1;
      n++;
    end
    cpu_if.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    cpu_if.req_valid = 1'b0;
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    cpu_if.req_valid  = 1'b0;
    cpu_if.req_we     = 1'b0;
    cpu_if.req_size   = 2'b00;
    cpu_if.req_signed = 1'b0;
    cpu_if.req_addr   = 32'd0;
    cpu_if.req_wdata  = 32'd0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      init_val[i] = $urandom;
      ref_mem[i]  = init_val[i];
    end
    repeat (3) @(negedge clk);
    init_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;

    // reset state
    chk("rst_ready", {31'd0, cpu_if.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, cpu_if.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, cpu_if.resp_err}, 32'd0);
    chk("rst_rdata", cpu_if.resp_rdata, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk_en = 1'b1;

    // 1: word store then word load
    run_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("t1_st_lat", last_lat, 2);
    chk("t1_mem4", mem[4], 32'hDEAD_BEEF);
    run_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    chk("t1_ld_lat", last_lat, 3);
    chk("t1_ld_data", last_rdata, 32'hDEAD_BEEF);
    chk("t1_ld_err", {31'd0, last_err}, 32'd0);

    // 2: byte loads with sign/zero extension
    run_req(1'b1, SZ_WORD, 1'b0, 32'h0, 32'h80F1_7F01);
    run_req(1'b0, SZ_BYTE, 1'b1, 32'h0, 32'h0);
    chk("t2_b0s", last_rdata, 32'h0000_0001);
    run_req(1'b0, SZ_BYTE, 1'b1, 32'h1, 32'h0);
    chk("t2_b1s", last_rdata, 32'h0000_007F);
    run_req(1'b0, SZ_BYTE, 1'b1, 32'h2, 32'h0);
    chk("t2_b2s", last_rdata, 32'hFFFF_FFF1);
    run_req(1'b0, SZ_BYTE, 1'b1, 32'h3, 32'h0);
    chk("t2_b3s", last_rdata, 32'hFFFF_FF80);
    run_req(1'b0, SZ_BYTE, 1'b0, 32'h3, 32'h0);
    chk("t2_b3u", last_rdata, 32'h0000_0080);

    // 3: sub-word stores (read-modify-write)
    run_req(1'b1, SZ_WORD, 1'b0, 32'h0, 32'h1122_3344);
    run_req(1'b1, SZ_BYTE, 1'b0, 32'h2, 32'h1234_56AA);
    chk("t3_byte_mem", mem[0], 32'h11AA_3344);
    chk("t3_byte_we", last_writes, 1);
    chk("t3_byte_lat", last_lat, 4);
    run_req(1'b1, SZ_WORD, 1'b0, 32'h0, 32'h1122_3344);
    run_req(1'b1, SZ_HALF, 1'b0, 32'h2, 32'h5555_BEEF);
    chk("t3_half_mem", mem[0], 32'hBEEF_3344);
    chk("t3_half_we", last_writes, 1);
    chk("t3_half_lat", last_lat, 4);

    // 4: error cases
    run_req(1'b0, SZ_HALF, 1'b0, 32'h1, 32'h0);
    chk("t4_half_err", {31'd0, last_err}, 32'd1);
    chk("t4_half_lat", last_lat, 1);
    run_req(1'b1, SZ_WORD, 1'b0, 32'h6, 32'hFFFF_FFFF);
    chk("t4_word_err", {31'd0, last_err}, 32'd1);
    chk("t4_word_we", last_writes, 0);
    run_req(1'b0, SZ_ILL, 1'b0, 32'h4, 32'h0);
    chk("t4_size_err", {31'd0, last_err}, 32'd1);
    chk("t4_size_rdata", last_rdata, 32'd0);
    run_req(1'b1, SZ_WORD, 1'b0, 32'h80, 32'h1234_5678);
    chk("t4_range_err", {31'd0, last_err}, 32'd1);
    chk("t4_mem0_kept", mem[0], 32'hBEEF_3344);

    // 5: reset during RMW_CAP of a byte store
    run_req(1'b1, SZ_WORD, 1'b0, 32'h0, 32'hCAFE_F00D);
    send(1'b1, SZ_BYTE, 1'b0, 32'h1, 32'h0000_0077);
    cpu_if.req_valid = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("t5_state", 32'(dbg_state), 32'(S_RMW_CAP));
    rst_n = 1'b0;
    in_flight = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_we_forced", {31'd0, mem_we}, 32'd0);
    repeat (2) begin
      @(negedge clk); #1;
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("t5_ready", {31'd0, cpu_if.req_ready}, 32'd1);
    chk("t5_state_idle", 32'(dbg_state), 32'(S_IDLE));
    chk("t5_mem0", mem[0], 32'hCAFE_F00D);
    idle(3);

    // 6: random back-to-back traffic
    for (int t = 0; t < 300; t++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = $urandom_range(0, 4 * MEM_WORDS + 15);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(4);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
